// File: rtl/modbus_pkg.sv
// Shared constants and state type for the Modbus holding-register access engine.
package modbus_pkg;

   localparam logic [7:0] FC_RD_HOLD   = 8'h03;
   localparam logic [7:0] FC_WR_SINGLE = 8'h06;
   localparam logic [7:0] FC_WR_MULTI  = 8'h10;

   localparam logic [7:0] EXC_NONE     = 8'h00;
   localparam logic [7:0] EXC_ILL_FUNC = 8'h01;
   localparam logic [7:0] EXC_ILL_ADDR = 8'h02;
   localparam logic [7:0] EXC_ILL_VAL  = 8'h03;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      RD_ADDR,
      RD_WAIT,
      RD_OUT,
      WR,
      DONE
   } state_t;

endpackage

// File: rtl/modbus_req_check.sv
// Combinational request validator: maps fc/addr/qty to a Modbus exception code.
// Optional write protection of the low register region with MODBUS_REG_WRPROT_EN.
module modbus_req_check
   import modbus_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_RD_QTY = 125,
   parameter int MAX_WR_QTY = 123,
   parameter int RO_REGS    = 0
) (
   input  logic [7:0]  fc,
   input  logic [15:0] addr,
   input  logic [15:0] qty,
   output logic [7:0]  exc
);

   localparam logic [16:0] ADDR_LIMIT = 17'(1) << ADDR_WIDTH;

   // 17-bit sum so that a range ending exactly at the top of the map is legal
   logic [16:0] range_end;
   assign range_end = {1'b0, addr} + {1'b0, qty};

   always_comb begin
      exc = EXC_NONE;
      if (fc != FC_RD_HOLD && fc != FC_WR_SINGLE && fc != FC_WR_MULTI)
         exc = EXC_ILL_FUNC;
      else if (qty == 16'd0 ||
               (fc == FC_RD_HOLD  && qty > 16'(MAX_RD_QTY)) ||
               (fc == FC_WR_MULTI && qty > 16'(MAX_WR_QTY)))
         exc = EXC_ILL_VAL;
      else if (range_end > ADDR_LIMIT)
         exc = EXC_ILL_ADDR;
`ifdef MODBUS_REG_WRPROT_EN
      else if (fc != FC_RD_HOLD && {1'b0, addr} < 17'(RO_REGS))
         exc = EXC_ILL_ADDR;
`endif
   end

endmodule

// File: rtl/modbus_reg_ctrl.sv
// Register-access engine between the Modbus RTU parser and holding-register RAM port A.
// Define MODBUS_REG_WRPROT_EN to reject writes below RO_REGS.
module modbus_reg_ctrl
   import modbus_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_RD_QTY = 125,
   parameter int MAX_WR_QTY = 123,
   parameter int RO_REGS    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_v,
   output logic                  req_rdy,
   input  logic [7:0]            req_fc,
   input  logic [15:0]           req_addr,
   input  logic [15:0]           req_qty,
   input  logic                  wr_v,
   input  logic [DATA_WIDTH-1:0] wr_d,
   output logic                  wr_rdy,
   output logic                  rd_v,
   output logic [DATA_WIDTH-1:0] rd_d,
   input  logic                  rd_rdy,
   output logic                  done,
   output logic [7:0]            exc,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [DATA_WIDTH-1:0] ram_d,
   output logic                  ram_w,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  fc_r;
   logic [15:0] ptr;
   logic [15:0] cnt;
   logic [7:0]  chk_exc;
   logic        wr_beat;

   modbus_req_check #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MAX_RD_QTY (MAX_RD_QTY),
      .MAX_WR_QTY (MAX_WR_QTY),
      .RO_REGS    (RO_REGS)
   ) u_check (
      .fc   (fc_r),
      .addr (ptr),
      .qty  (cnt),
      .exc  (chk_exc)
   );

   // WR keeps wr_rdy low once cnt hits zero so the last ram_w cycle completes before done
   assign req_rdy = (state == IDLE);
   assign rd_v    = (state == RD_OUT);
   assign wr_rdy  = (state == WR) && (cnt != 16'd0);
   assign done    = (state == DONE);
   assign wr_beat = wr_v && wr_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_v) state_nxt = CHECK;
         CHECK: begin
            if (chk_exc != EXC_NONE)    state_nxt = DONE;
            else if (fc_r == FC_RD_HOLD) state_nxt = RD_ADDR;
            else                         state_nxt = WR;
         end
         RD_ADDR: state_nxt = RD_WAIT;
         RD_WAIT: state_nxt = RD_OUT;
         RD_OUT:  if (rd_rdy) state_nxt = (cnt == 16'd1) ? DONE : RD_ADDR;
         WR:      if (cnt == 16'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ram_a is loaded one state early so it is already valid throughout RD_ADDR
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fc_r  <= 8'h00;
         ptr   <= 16'h0000;
         cnt   <= 16'h0000;
         exc   <= EXC_NONE;
         rd_d  <= '0;
         ram_a <= '0;
         ram_d <= '0;
         ram_w <= 1'b0;
      end else begin
         ram_w <= 1'b0;
         case (state)
            IDLE: begin
               if (req_v) begin
                  fc_r <= req_fc;
                  ptr  <= req_addr;
                  cnt  <= (req_fc == FC_WR_SINGLE) ? 16'd1 : req_qty;
               end
            end
            CHECK: begin
               exc <= chk_exc;
               if (chk_exc == EXC_NONE && fc_r == FC_RD_HOLD)
                  ram_a <= ADDR_WIDTH'(ptr);
            end
            RD_WAIT: rd_d <= ram_q;
            RD_OUT: begin
               if (rd_rdy) begin
                  ptr   <= ptr + 16'd1;
                  cnt   <= cnt - 16'd1;
                  ram_a <= ADDR_WIDTH'(ptr + 16'd1);
               end
            end
            WR: begin
               if (wr_beat) begin
                  ram_w <= 1'b1;
                  ram_a <= ADDR_WIDTH'(ptr);
                  ram_d <= wr_d;
                  ptr   <= ptr + 16'd1;
                  cnt   <= cnt - 16'd1;
               end
            end
            DONE: exc <= EXC_NONE;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_modbus_reg_ctrl.sv
// Scoreboard testbench for modbus_reg_ctrl with a registered-output RAM model.
// Build with MODBUS_REG_WRPROT_EN to also exercise the write-protected region (RO_REGS=8).
module tb_modbus_reg_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_v = 1'b0;
   logic        req_rdy;
   logic [7:0]  req_fc = 8'h00;
   logic [15:0] req_addr = 16'h0000;
   logic [15:0] req_qty = 16'h0000;
   logic        wr_v = 1'b0;
   logic [15:0] wr_d = 16'h0000;
   logic        wr_rdy;
   logic        rd_v;
   logic [15:0] rd_d;
   logic        rd_rdy;
   logic        done;
   logic [7:0]  exc;
   logic [15:0] ram_a;
   logic [15:0] ram_d;
   logic        ram_w;
   logic [15:0] ram_q;

   logic [15:0] mem    [0:65535];
   logic [15:0] shadow [0:65535];

   logic [15:0] rd_exp_q  [$];
   logic [31:0] wr_exp_q  [$];
   logic [7:0]  exc_exp_q [$];
   logic [15:0] wr_words  [$];

   int   assert_count = 0;
   int   fail_count = 0;
   logic toggle_mode = 1'b0;
   logic stalled = 1'b0;
   logic [15:0] stall_data = 16'h0000;
   logic wr_rdy_seen = 1'b0;

   always #5 clk = ~clk;

   modbus_reg_ctrl #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16),
      .MAX_RD_QTY (125),
      .MAX_WR_QTY (123),
      .RO_REGS    (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_v    (req_v),
      .req_rdy  (req_rdy),
      .req_fc   (req_fc),
      .req_addr (req_addr),
      .req_qty  (req_qty),
      .wr_v     (wr_v),
      .wr_d     (wr_d),
      .wr_rdy   (wr_rdy),
      .rd_v     (rd_v),
      .rd_d     (rd_d),
      .rd_rdy   (rd_rdy),
      .done     (done),
      .exc      (exc),
      .ram_a    (ram_a),
      .ram_d    (ram_d),
      .ram_w    (ram_w),
      .ram_q    (ram_q)
   );

   // RAM port A: synchronous write, registered read with one-cycle latency
   always @(posedge clk) begin
      if (ram_w) mem[ram_a] <= ram_d;
      ram_q <= mem[ram_a];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] modelExc(input logic [7:0] fc, input int addr, input int qty);
      int q;
      q = (fc == 8'h06) ? 1 : qty;
      if (fc != 8'h03 && fc != 8'h06 && fc != 8'h10) return 8'h01;
      if (q == 0 || (fc == 8'h03 && q > 125) || (fc == 8'h10 && q > 123)) return 8'h03;
      if (addr + q > 65536) return 8'h02;
`ifdef MODBUS_REG_WRPROT_EN
      if (fc != 8'h03 && addr < 8) return 8'h02;
`endif
      return 8'h00;
   endfunction

   task automatic checkResetValues();
      checkOutput("rst_req_rdy", 32'(req_rdy), 32'd1);
      checkOutput("rst_rd_v",    32'(rd_v),    32'd0);
      checkOutput("rst_rd_d",    32'(rd_d),    32'd0);
      checkOutput("rst_wr_rdy",  32'(wr_rdy),  32'd0);
      checkOutput("rst_done",    32'(done),    32'd0);
      checkOutput("rst_exc",     32'(exc),     32'd0);
      checkOutput("rst_ram_w",   32'(ram_w),   32'd0);
      checkOutput("rst_ram_a",   32'(ram_a),   32'd0);
      checkOutput("rst_ram_d",   32'(ram_d),   32'd0);
   endtask

   // Issues one request, feeds write data from wr_words, waits for done and checks latency
   task automatic applyStimulus(input logic [7:0] fc, input int addr, input int qty, input int exp_lat);
      logic [7:0] e;
      int eq;
      int offered;
      int idx;
      int cycles;
      int guard;
      logic seen;
      logic beat;
      e  = modelExc(fc, addr, qty);
      eq = (fc == 8'h06) ? 1 : qty;
      exc_exp_q.push_back(e);
      offered = 0;
      if (fc == 8'h06 || fc == 8'h10)
         offered = (eq < wr_words.size()) ? eq : wr_words.size();
      if (e == 8'h00) begin
         for (int i = 0; i < eq; i++) begin
            if (fc == 8'h03) rd_exp_q.push_back(shadow[addr + i]);
            else begin
               wr_exp_q.push_back({16'(addr + i), wr_words[i]});
               shadow[addr + i] = wr_words[i];
            end
         end
      end
      guard = 0;
      while (!req_rdy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("req_rdy", 32'(req_rdy), 32'd1);
      @(posedge clk); #1;
      req_v = 1'b1; req_fc = fc; req_addr = 16'(addr); req_qty = 16'(qty);
      @(posedge clk); #1;
      req_v = 1'b0;
      idx = 0;
      wr_v = (idx < offered);
      wr_d = (idx < offered) ? wr_words[idx] : 16'h0000;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < 1000) begin
         @(negedge clk);
         cycles++;
         beat = wr_v && wr_rdy;
         seen = done;
         @(posedge clk); #1;
         if (beat) idx++;
         wr_v = (idx < offered);
         wr_d = (idx < offered) ? wr_words[idx] : 16'h0000;
      end
      wr_v = 1'b0;
      checkOutput("done_seen", 32'(seen), 32'd1);
      if (exp_lat > 0) checkOutput("done_latency", 32'(cycles), 32'(exp_lat));
   endtask

   initial begin
      rd_rdy = 1'b1;
      forever begin
         @(posedge clk); #1;
         rd_rdy = toggle_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard: pop and compare on every read transfer, RAM write and done pulse
   always @(negedge clk) begin
      if (rst) begin
         if (wr_rdy) wr_rdy_seen = 1'b1;
         if (stalled) begin
            checkOutput("rd_stall_v", 32'(rd_v), 32'd1);
            checkOutput("rd_stall_d", 32'(rd_d), 32'(stall_data));
         end
         if (rd_v && rd_rdy) begin
            checkOutput("rd_pending", 32'(rd_exp_q.size() > 0), 32'd1);
            if (rd_exp_q.size() > 0) checkOutput("rd_data", 32'(rd_d), 32'(rd_exp_q.pop_front()));
         end
         stalled    = rd_v && !rd_rdy;
         stall_data = rd_d;
         if (ram_w) begin
            checkOutput("wr_pending", 32'(wr_exp_q.size() > 0), 32'd1);
            if (wr_exp_q.size() > 0) checkOutput("ram_write", {ram_a, ram_d}, wr_exp_q.pop_front());
         end
         if (done) begin
            checkOutput("done_pending", 32'(exc_exp_q.size() > 0), 32'd1);
            if (exc_exp_q.size() > 0) checkOutput("done_exc", 32'(exc), 32'(exc_exp_q.pop_front()));
         end
      end else begin
         stalled = 1'b0;
      end
   end

   initial begin
      int idx;
      int guard;
      logic beat;
      for (int i = 0; i < 65536; i++) begin
         mem[i]    = 16'(i) ^ 16'hC3C3;
         shadow[i] = 16'(i) ^ 16'hC3C3;
      end
      mem[16'h10] = 16'h00A1; shadow[16'h10] = 16'h00A1;
      mem[16'h11] = 16'h00A2; shadow[16'h11] = 16'h00A2;
      mem[16'h12] = 16'h00A3; shadow[16'h12] = 16'h00A3;

      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 checkResetValues();
      rst = 1'b1;

      applyStimulus(8'h03, 'h10, 3, 11);
      wr_words = '{16'h1234, 16'h5678};
      applyStimulus(8'h10, 'h20, 2, 5);
      applyStimulus(8'h03, 'h20, 2, 8);
      applyStimulus(8'h05, 'h00, 1, 2);
      applyStimulus(8'h03, 'h00, 126, 2);
      applyStimulus(8'h03, 'hFFFF, 2, 2);
      applyStimulus(8'h03, 'hFFFF, 1, 5);
      applyStimulus(8'h05, 'h00, 0, 2);
      applyStimulus(8'h10, 'hFFFF, 200, 2);
      applyStimulus(8'h10, 'h00, 0, 2);
      applyStimulus(8'h10, 'h00, 124, 2);
      wr_words = '{16'hBEEF};
      applyStimulus(8'h06, 'h30, 0, 4);
      applyStimulus(8'h03, 'h00, 125, 377);

      toggle_mode = 1'b1;
      applyStimulus(8'h03, 'h1E, 20, -1);
      toggle_mode = 1'b0;

      // Abort a 4-word write after two beats; both landed words must persist
      wr_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      wr_exp_q.push_back({16'h0040, 16'h1111}); shadow[16'h40] = 16'h1111;
      wr_exp_q.push_back({16'h0041, 16'h2222}); shadow[16'h41] = 16'h2222;
      @(posedge clk); #1;
      req_v = 1'b1; req_fc = 8'h10; req_addr = 16'h0040; req_qty = 16'd4;
      @(posedge clk); #1;
      req_v = 1'b0; wr_v = 1'b1; wr_d = wr_words[0];
      idx = 0; guard = 0;
      while (idx < 2 && guard < 20) begin
         @(negedge clk);
         beat = wr_v && wr_rdy;
         @(posedge clk); #1;
         if (beat) idx++;
         wr_d = wr_words[idx];
         guard++;
      end
      wr_v = 1'b0;
      checkOutput("abort_beats", 32'(idx), 32'd2);
      @(posedge clk); #1;
      rst = 1'b0;
      #1 checkResetValues();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      applyStimulus(8'h03, 'h40, 4, 14);

`ifdef MODBUS_REG_WRPROT_EN
      wr_rdy_seen = 1'b0;
      wr_words = '{16'h7777};
      applyStimulus(8'h06, 3, 1, 2);
      checkOutput("wrprot_wr_rdy", 32'(wr_rdy_seen), 32'd0);
      applyStimulus(8'h06, 8, 1, 4);
      applyStimulus(8'h03, 3, 1, 5);
`endif

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rd_q_empty",  32'(rd_exp_q.size()),  32'd0);
      checkOutput("wr_q_empty",  32'(wr_exp_q.size()),  32'd0);
      checkOutput("exc_q_empty", 32'(exc_exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
